// File: rtl/fx_bus_pkg.sv
// fx_bus_pkg: frame headers, response codes, address width and bridge FSM states.
package fx_bus_pkg;
  localparam logic [7:0] FX_HDR_WR = 8'hA5;
  localparam logic [7:0] FX_HDR_RD = 8'h5A;
  localparam logic [7:0] FX_ACK = 8'hAC;
  localparam logic [7:0] FX_NAK = 8'hEE;
  localparam int FX_ADDR_W = 22;
  typedef enum logic [3:0] {
    IDLE, ADR2, ADR1, ADR0, DATA, CHK, WR, RD, RCAP, RESP
  } fx_state_e;
endpackage

// File: rtl/fx_byte_timer.sv
// fx_byte_timer: inter-byte watchdog, counts while run and not cleared, flags at the limit.
module fx_byte_timer #(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);
  logic [15:0] cnt_q;
  assign expired = run && cnt_q == TIMEOUT_CYC;
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clear || !run) cnt_q <= '0;
    else if (!expired) cnt_q <= cnt_q + 16'd1;
endmodule

// File: rtl/fx_cmd_bridge.sv
// fx_cmd_bridge: byte-stream command frames to fx bus write/read strobes with one response byte.
// Define FX_BRIDGE_CHKSUM_EN to require a trailing XOR checksum byte on every frame.
module fx_cmd_bridge
  import fx_bus_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic                 clk_sys,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_vld,
  output logic                 rx_rdy,
  output logic [7:0]           tx_data,
  output logic                 tx_vld,
  input  logic                 tx_rdy,
  output logic [FX_ADDR_W-1:0] fx_waddr,
  output logic                 fx_wr,
  output logic [7:0]           fx_data,
  output logic [FX_ADDR_W-1:0] fx_raddr,
  output logic                 fx_rd,
  input  logic [7:0]           fx_q,
  output logic                 busy,
  output logic [7:0]           err_cnt
);
  fx_state_e state_q;
  logic [FX_ADDR_W-1:0] addr_q, fx_waddr_q, fx_raddr_q;
  logic [7:0] data_q, fx_data_q, tx_data_q, err_q, err_d;
  logic is_wr_q, tx_vld_q, fx_wr_q, fx_rd_q, acc, run, expired;
`ifdef FX_BRIDGE_CHKSUM_EN
  logic [7:0] chk_q;
`endif
  // rx_rdy is gated by rst_n so it reads low during reset and high on the first cycle after
  assign rx_rdy = rst_n && state_q inside {IDLE, ADR2, ADR1, ADR0, DATA, CHK};
  assign acc = rx_vld && rx_rdy;
  assign run = state_q inside {ADR2, ADR1, ADR0, DATA, CHK};
  assign err_d = err_q + {7'd0, err_q != 8'hFF};
  assign busy = state_q != IDLE;
  assign tx_data = tx_data_q;
  assign tx_vld = tx_vld_q;
  assign fx_waddr = fx_waddr_q;
  assign fx_raddr = fx_raddr_q;
  assign fx_data = fx_data_q;
  assign fx_wr = fx_wr_q;
  assign fx_rd = fx_rd_q;
  assign err_cnt = err_q;
  fx_byte_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk_sys(clk_sys), .rst_n(rst_n), .clear(acc), .run(run), .expired(expired)
  );
  // Strobes and their address/data are loaded on the edge entering WR/RD so they are valid that whole cycle
  always_ff @(posedge clk_sys or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      data_q <= '0;
      is_wr_q <= 1'b0;
      tx_data_q <= '0;
      tx_vld_q <= 1'b0;
      fx_wr_q <= 1'b0;
      fx_rd_q <= 1'b0;
      fx_waddr_q <= '0;
      fx_raddr_q <= '0;
      fx_data_q <= '0;
      err_q <= '0;
`ifdef FX_BRIDGE_CHKSUM_EN
      chk_q <= '0;
`endif
    end else begin
      fx_wr_q <= 1'b0;
      fx_rd_q <= 1'b0;
`ifdef FX_BRIDGE_CHKSUM_EN
      if (acc) chk_q <= (state_q == IDLE ? 8'h00 : chk_q) ^ rx_data;
`endif
      if (expired && !acc) begin
        state_q <= IDLE;
        err_q <= err_d;
      end else
        case (state_q)
          IDLE: if (acc) begin
            is_wr_q <= rx_data == FX_HDR_WR;
            if (rx_data == FX_HDR_WR || rx_data == FX_HDR_RD) state_q <= ADR2;
            else err_q <= err_d;
          end
          ADR2: if (acc) begin
            addr_q[21:16] <= rx_data[5:0];
            state_q <= ADR1;
          end
          ADR1: if (acc) begin
            addr_q[15:8] <= rx_data;
            state_q <= ADR0;
          end
          ADR0: if (acc) begin
            addr_q[7:0] <= rx_data;
`ifdef FX_BRIDGE_CHKSUM_EN
            state_q <= is_wr_q ? DATA : CHK;
`else
            state_q <= is_wr_q ? DATA : RD;
            fx_rd_q <= !is_wr_q;
            if (!is_wr_q) fx_raddr_q <= {addr_q[21:8], rx_data};
`endif
          end
          DATA: if (acc) begin
            data_q <= rx_data;
`ifdef FX_BRIDGE_CHKSUM_EN
            state_q <= CHK;
`else
            state_q <= WR;
            fx_wr_q <= 1'b1;
            fx_waddr_q <= addr_q;
            fx_data_q <= rx_data;
`endif
          end
`ifdef FX_BRIDGE_CHKSUM_EN
          CHK: if (acc) begin
            if (chk_q == rx_data) begin
              state_q <= is_wr_q ? WR : RD;
              fx_wr_q <= is_wr_q;
              fx_rd_q <= !is_wr_q;
              if (is_wr_q) begin
                fx_waddr_q <= addr_q;
                fx_data_q <= data_q;
              end else fx_raddr_q <= addr_q;
            end else begin
              state_q <= RESP;
              tx_data_q <= FX_NAK;
              tx_vld_q <= 1'b1;
              err_q <= err_d;
            end
          end
`endif
          WR: begin
            state_q <= RESP;
            tx_data_q <= FX_ACK;
            tx_vld_q <= 1'b1;
          end
          RD: state_q <= RCAP;
          RCAP: begin
            state_q <= RESP;
            tx_data_q <= fx_q;
            tx_vld_q <= 1'b1;
          end
          RESP: if (tx_rdy) begin
            state_q <= IDLE;
            tx_vld_q <= 1'b0;
          end
          default: state_q <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_fx_cmd_bridge.sv
// tb_fx_cmd_bridge: directed and random frames checked against a frame-level model of the bridge.
module tb_fx_cmd_bridge;
  localparam logic [15:0] TO = 16'd100;
  logic clk_sys = 1'b0, rst_n = 1'b0, rx_vld = 1'b0, tx_rdy = 1'b0;
  logic [7:0] rx_data = '0, fx_q = '0;
  logic rx_rdy, tx_vld, fx_wr, fx_rd, busy;
  logic [7:0] tx_data, fx_data, err_cnt;
  logic [21:0] fx_waddr, fx_raddr;
  int total = 0, bad = 0;
  int cyc = 0, wr_n = 0, rd_n = 0, both_n = 0, rd_cyc = 0;
  logic [21:0] wa_seen = '0, ra_seen = '0, last_wa = '0, last_ra = '0;
  logic [7:0] wd_seen = '0, last_wd = '0, rd_val = '0;
  logic pend = 1'b0;
  int err_exp = 0;

  fx_cmd_bridge #(.TIMEOUT_CYC(TO)) dut (
    .clk_sys(clk_sys), .rst_n(rst_n), .rx_data(rx_data), .rx_vld(rx_vld), .rx_rdy(rx_rdy),
    .tx_data(tx_data), .tx_vld(tx_vld), .tx_rdy(tx_rdy), .fx_waddr(fx_waddr), .fx_wr(fx_wr),
    .fx_data(fx_data), .fx_raddr(fx_raddr), .fx_rd(fx_rd), .fx_q(fx_q), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk_sys = ~clk_sys;
  always @(posedge clk_sys) cyc <= cyc + 1;

  // Device side: fx_q carries the read byte only in the cycle after fx_rd, noise otherwise
  always @(negedge clk_sys) begin
    fx_q = pend ? rd_val : 8'($urandom);
    pend = fx_rd;
    if (fx_wr) begin wr_n++; wa_seen = fx_waddr; wd_seen = fx_data; end
    if (fx_rd) begin rd_n++; rd_cyc = cyc; ra_seen = fx_raddr; end
    if (fx_wr && fx_rd) both_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_inc(input int e);
    return e >= 255 ? 255 : e + 1;
  endfunction

  task automatic send(input logic [7:0] b);
    int n = 0;
    rx_data = b;
    rx_vld = 1'b1;
    while (!rx_rdy && n < 200) begin @(negedge clk_sys); n++; end
    if (!rx_rdy) chk("rx_rdy_timeout", rx_rdy, 1);
    @(negedge clk_sys);
    rx_vld = 1'b0;
  endtask

  task automatic send_frame(input bit is_wr, input logic [21:0] a, input logic [7:0] d, input logic [1:0] hi);
    logic [7:0] b [5];
    logic [7:0] cs = 8'h00;
    int n;
    b[0] = is_wr ? 8'hA5 : 8'h5A;
    b[1] = {hi, a[21:16]};
    b[2] = a[15:8];
    b[3] = a[7:0];
    b[4] = d;
    n = is_wr ? 5 : 4;
    for (int i = 0; i < n; i++) begin cs ^= b[i]; send(b[i]); end
`ifdef FX_BRIDGE_CHKSUM_EN
    send(cs);
`endif
  endtask

  task automatic get_resp(input string tag, input logic [7:0] exp, input int hold, output int rc);
    int n = 0;
    while (!tx_vld && n < 50) begin @(negedge clk_sys); n++; end
    rc = cyc;
    chk({tag, "_vld"}, tx_vld, 1);
    chk({tag, "_data"}, tx_data, exp);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_sys);
      chk({tag, "_hold_vld"}, tx_vld, 1);
      chk({tag, "_hold_data"}, tx_data, exp);
    end
    tx_rdy = 1'b1;
    @(negedge clk_sys);
    tx_rdy = 1'b0;
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic do_write(input logic [21:0] a, input logic [7:0] d, input logic [1:0] hi, input int hold);
    int w0 = wr_n, r0 = rd_n, rc;
    send_frame(1'b1, a, d, hi);
    get_resp("wr_resp", 8'hAC, hold, rc);
    last_wa = a;
    last_wd = d;
    chk("wr_pulses", wr_n, w0 + 1);
    chk("wr_no_rd", rd_n, r0);
    chk("wr_addr", wa_seen, a);
    chk("wr_data", wd_seen, d);
    chk("wr_raddr_hold", fx_raddr, last_ra);
  endtask

  task automatic do_read(input logic [21:0] a, input logic [7:0] v, input logic [1:0] hi, input int hold);
    int w0 = wr_n, r0 = rd_n, rc;
    rd_val = v;
    send_frame(1'b0, a, 8'h00, hi);
    get_resp("rd_resp", v, hold, rc);
    last_ra = a;
    chk("rd_pulses", rd_n, r0 + 1);
    chk("rd_no_wr", wr_n, w0);
    chk("rd_addr", ra_seen, a);
    chk("rd_latency", rc - rd_cyc, 2);
    chk("rd_waddr_hold", fx_waddr, last_wa);
    chk("rd_wdata_hold", fx_data, last_wd);
  endtask

  initial begin
    int w0, r0;
    logic [7:0] h;
    repeat (3) @(negedge clk_sys);
    chk("rst_rx_rdy", rx_rdy, 0);
    chk("rst_tx_vld", tx_vld, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_waddr", fx_waddr, 0);
    chk("rst_raddr", fx_raddr, 0);
    chk("rst_data", fx_data, 0);
    chk("rst_strobes", {fx_wr, fx_rd}, 0);
    rst_n = 1'b1;
    #1 chk("rel_rx_rdy", rx_rdy, 1);
    @(negedge clk_sys);

    do_write(22'h010022, 8'h3C, 2'b00, 0);
    do_read(22'h010022, 8'h3C, 2'b00, 0);

    w0 = wr_n; r0 = rd_n;
    send(8'h77);
    err_exp = sat_inc(err_exp);
    repeat (3) @(negedge clk_sys);
    chk("badhdr_err", err_cnt, err_exp);
    chk("badhdr_busy", busy, 0);
    chk("badhdr_no_fx", wr_n + rd_n, w0 + r0);
    do_read(22'h2ABCDE, 8'h5B, 2'b11, 1);

    w0 = wr_n; r0 = rd_n;
    send(8'hA5);
    send(8'h01);
    repeat (int'(TO) - 2) @(negedge clk_sys);
    chk("to_still_busy", busy, 1);
    repeat (5) @(negedge clk_sys);
    err_exp = sat_inc(err_exp);
    chk("to_idle", busy, 0);
    chk("to_err", err_cnt, err_exp);
    chk("to_no_fx", wr_n + rd_n, w0 + r0);
    chk("to_no_resp", tx_vld, 0);

    do_write(22'h3FFFFF, 8'hC3, 2'b10, 100);

`ifdef FX_BRIDGE_CHKSUM_EN
    begin
      int rc;
      w0 = wr_n;
      foreach (h[i]) h[i] = 1'b0;
      send(8'hA5); send(8'h01); send(8'h00); send(8'h22); send(8'h3C); send(8'hBB);
      err_exp = sat_inc(err_exp);
      get_resp("cs_nak", 8'hEE, 2, rc);
      chk("cs_no_wr", wr_n, w0);
      chk("cs_err", err_cnt, err_exp);
      chk("cs_waddr_hold", fx_waddr, last_wa);
    end
`endif

    for (int k = 0; k < 24; k++) begin
      logic [21:0] a;
      logic [7:0] d;
      a = 22'($urandom);
      d = 8'($urandom);
      if ($urandom_range(1)) do_write(a, d, 2'($urandom), $urandom_range(3));
      else do_read(a, d, 2'($urandom), $urandom_range(3));
    end
    chk("rand_err", err_cnt, err_exp);

    for (int k = 0; k < 260; k++) begin
      h = 8'($urandom);
      if (h == 8'hA5 || h == 8'h5A) h = 8'h00;
      send(h);
      err_exp = sat_inc(err_exp);
    end
    @(negedge clk_sys);
    chk("sat_err", err_cnt, err_exp);
    chk("sat_busy", busy, 0);
    do_read(22'h000001, 8'h81, 2'b01, 0);
    chk("sat_hold", err_cnt, 255);

    w0 = wr_n;
    send(8'hA5); send(8'h12); send(8'h34); send(8'h56);
    rst_n = 1'b0;
    #1;
    chk("midf_rx_rdy", rx_rdy, 0);
    chk("midf_err", err_cnt, 0);
    chk("midf_waddr", fx_waddr, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    #1 chk("midf_rel_rdy", rx_rdy, 1);
    err_exp = 0; last_wa = '0; last_ra = '0; last_wd = '0;
    repeat (4) @(negedge clk_sys);
    chk("midf_no_wr", wr_n, w0);
    chk("midf_busy", busy, 0);

    send_frame(1'b1, 22'h155555, 8'h99, 2'b00);
    begin
      int n = 0;
      while (!tx_vld && n < 50) begin @(negedge clk_sys); n++; end
    end
    chk("midr_in_resp", tx_vld, 1);
    w0 = wr_n;
    rst_n = 1'b0;
    #1;
    chk("midr_tx_vld", tx_vld, 0);
    chk("midr_tx_data", tx_data, 0);
    chk("midr_busy", busy, 0);
    chk("midr_data", fx_data, 0);
    @(negedge clk_sys);
    rst_n = 1'b1;
    #1 chk("midr_rel_rdy", rx_rdy, 1);
    repeat (3) @(negedge clk_sys);
    chk("midr_no_wr", wr_n, w0);
    chk("midr_no_tx", tx_vld, 0);
    do_write(22'h0000AA, 8'h55, 2'b00, 0);

    chk("no_overlap", both_n, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
